// File: rtl/clock_meter_pkg.sv
// Shared types and helpers for the clock period meter.
package clock_meter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      STOPPED = 2'd3
   } meter_state_t;

   // Largest value representable in a counter of the given width.
   function automatic longint unsigned count_max(input int unsigned width);
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level and produces one-cycle rise/fall pulses.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   sync_s;

   assign sync_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         hist_q <= sync_s;
      end
   end

   assign rise = sync_s & ~hist_q;
   assign fall = ~sync_s & hist_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous clock in system-clock cycles.
// Result handshake: a transfer happens on any cycle where result_valid and result_ready are both 1.
module clock_period_meter
   import clock_meter_pkg::*;
#(
   parameter int          COUNT_WIDTH = 24,
   parameter int          SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 10000000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   meas_clock,
   input  logic                   enable,
   input  logic                   result_ready,
   output logic                   result_valid,
   output logic [COUNT_WIDTH-1:0] period,
   output logic [COUNT_WIDTH-1:0] high_time,
   output logic                   overrun,
   output logic                   stopped,
   output meter_state_t           state_dbg
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(count_max(COUNT_WIDTH));
   localparam logic [COUNT_WIDTH-1:0] TIMEOUT_C = COUNT_WIDTH'(TIMEOUT);
   localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

   meter_state_t           state_q, state_d;
   logic [COUNT_WIDTH-1:0] counter_q, counter_d;
   logic [COUNT_WIDTH-1:0] hi_latch_q, hi_latch_d;
   logic [COUNT_WIDTH-1:0] period_q, period_d;
   logic [COUNT_WIDTH-1:0] high_time_q, high_time_d;
   logic                   valid_q, valid_d;
   logic                   overrun_q, overrun_d;
   logic                   stopped_q, stopped_d;
   logic [COUNT_WIDTH-1:0] counter_inc;
   logic                   complete;
   logic                   rise;
   logic                   fall;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge (
      .clock    (clock),
      .reset    (reset),
      .async_in (meas_clock),
      .rise     (rise),
      .fall     (fall)
   );

   assign counter_inc = (counter_q == COUNT_MAX) ? counter_q : counter_q + ONE;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         counter_q   <= '0;
         hi_latch_q  <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         stopped_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         hi_latch_q  <= hi_latch_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         stopped_q   <= stopped_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      counter_d   = counter_q;
      hi_latch_d  = hi_latch_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      stopped_d   = stopped_q;
      complete    = 1'b0;

      if (valid_q && result_ready) begin
         valid_d = 1'b0;
      end

      // Disabling discards the measurement but keeps any pending result.
      if (!enable) begin
         state_d   = IDLE;
         counter_d = '0;
         stopped_d = 1'b0;
         overrun_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               counter_d = '0;
               state_d   = ARM;
            end
            ARM: begin
               if (rise) begin
                  state_d   = MEASURE;
                  counter_d = ONE;
               end
            end
            MEASURE: begin
               if (fall) begin
                  hi_latch_d = counter_q;
               end
               // A rise on the timeout cycle still completes the period.
               if (rise) begin
                  complete  = 1'b1;
                  counter_d = ONE;
               end else begin
                  counter_d = counter_inc;
                  if (counter_q == TIMEOUT_C) begin
                     state_d   = STOPPED;
                     stopped_d = 1'b1;
                  end
               end
            end
            STOPPED: begin
               counter_d = counter_inc;
               if (rise) begin
                  state_d   = MEASURE;
                  counter_d = ONE;
                  stopped_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (complete) begin
         period_d    = counter_q;
         high_time_d = hi_latch_q;
         valid_d     = 1'b1;
         if (valid_q && !result_ready) begin
            overrun_d = 1'b1;
         end
      end
   end

   assign result_valid = valid_q;
   assign period       = period_q;
   assign high_time    = high_time_q;
   assign overrun      = overrun_q;
   assign stopped      = stopped_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: waveform tasks, result scoreboard, summary.
module tb_clock_period_meter;
   import clock_meter_pkg::*;

   localparam int W  = 24;
   localparam int TO = 50;

   logic clock        = 1'b0;
   logic reset        = 1'b0;
   logic meas_clock   = 1'b0;
   logic enable       = 1'b0;
   logic result_ready = 1'b0;
   logic             result_valid;
   logic [W-1:0]     period;
   logic [W-1:0]     high_time;
   logic             overrun;
   logic             stopped;
   meter_state_t     state_dbg;

   int checks_total  = 0;
   int checks_passed = 0;
   logic [2*W-1:0] exp_q[$];

   always #5 clock = ~clock;

   clock_period_meter #(
      .COUNT_WIDTH (W),
      .SYNC_STAGES (2),
      .TIMEOUT     (TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .meas_clock   (meas_clock),
      .enable       (enable),
      .result_ready (result_ready),
      .result_valid (result_valid),
      .period       (period),
      .high_time    (high_time),
      .overrun      (overrun),
      .stopped      (stopped),
      .state_dbg    (state_dbg)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic meas_cycle(input int h, input int l);
      meas_clock = 1'b1;
      wait_n(h);
      meas_clock = 1'b0;
      wait_n(l);
   endtask

   task automatic push_exp(input int p, input int h, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({W'(p), W'(h)});
   endtask

   task automatic restart();
      enable = 1'b0;
      wait_n(1);
      enable = 1'b1;
      wait_n(1);
   endtask

   // Scoreboard: every accepted result must match the next expected entry.
   always @(negedge clock) begin
      logic [2*W-1:0] e;
      #2;
      if (reset && result_valid && result_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(result_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("result_period", 64'(period), 64'(e[2*W-1:W]));
            check("result_high_time", 64'(high_time), 64'(e[W-1:0]));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      wait_n(2);
      check("rst_valid", 64'(result_valid), 64'd0);
      check("rst_period", 64'(period), 64'd0);
      check("rst_high_time", 64'(high_time), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      check("rst_stopped", 64'(stopped), 64'd0);
      check("rst_state", 64'(state_dbg), 64'(IDLE));
      reset = 1'b1;
      wait_n(2);
      check("idle_while_disabled", 64'(state_dbg), 64'(IDLE));

      // 4 high / 6 low: first rise arms, then period 10 high 4
      result_ready = 1'b1;
      enable       = 1'b1;
      push_exp(10, 4, 3);
      repeat (4) meas_cycle(4, 6);
      check("t1_overrun", 64'(overrun), 64'd0);
      check("t1_drain", 64'(exp_q.size()), 64'd0);

      // 3/3, one transition period of 3+23, then 20/30 (period equals TIMEOUT)
      restart();
      push_exp(6, 3, 4);
      push_exp(26, 3, 1);
      push_exp(50, 20, 2);
      repeat (4) meas_cycle(3, 3);
      meas_cycle(3, 23);
      repeat (3) meas_cycle(20, 30);
      check("t2_drain", 64'(exp_q.size()), 64'd0);

      // Back-pressure: second completion overwrites and sets overrun
      result_ready = 1'b0;
      restart();
      repeat (3) meas_cycle(4, 6);
      check("t3_valid_held", 64'(result_valid), 64'd1);
      check("t3_period", 64'(period), 64'd10);
      check("t3_high_time", 64'(high_time), 64'd4);
      check("t3_overrun_set", 64'(overrun), 64'd1);
      push_exp(10, 4, 1);
      result_ready = 1'b1;
      wait_n(1);
      result_ready = 1'b0;
      check("t3_valid_dropped", 64'(result_valid), 64'd0);
      check("t3_overrun_sticky", 64'(overrun), 64'd1);
      check("t3_drain", 64'(exp_q.size()), 64'd0);

      // Timeout: stopped exactly TIMEOUT+1 cycles after the last rise pulse
      result_ready = 1'b1;
      restart();
      push_exp(10, 4, 1);
      meas_cycle(4, 6);
      meas_clock = 1'b1;
      wait_n(4);
      meas_clock = 1'b0;
      wait_n(48);
      check("t4_not_yet_stopped", 64'(stopped), 64'd0);
      check("t4_state_measure", 64'(state_dbg), 64'(MEASURE));
      wait_n(1);
      check("t4_stopped", 64'(stopped), 64'd1);
      check("t4_state_stopped", 64'(state_dbg), 64'(STOPPED));
      check("t4_no_result", 64'(exp_q.size()), 64'd0);
      push_exp(10, 4, 1);
      meas_cycle(4, 6);
      check("t4_stopped_cleared", 64'(stopped), 64'd0);
      check("t4_rearmed", 64'(state_dbg), 64'(MEASURE));
      meas_cycle(4, 6);
      check("t4_drain", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset with a pending result mid-measurement
      result_ready = 1'b0;
      restart();
      repeat (2) meas_cycle(4, 6);
      check("t5_pending", 64'(result_valid), 64'd1);
      #3;
      reset = 1'b0;
      #1;
      check("t5_rst_valid", 64'(result_valid), 64'd0);
      check("t5_rst_period", 64'(period), 64'd0);
      check("t5_rst_high_time", 64'(high_time), 64'd0);
      check("t5_rst_overrun", 64'(overrun), 64'd0);
      check("t5_rst_stopped", 64'(stopped), 64'd0);
      check("t5_rst_state", 64'(state_dbg), 64'(IDLE));
      wait_n(1);
      reset        = 1'b1;
      result_ready = 1'b1;
      push_exp(10, 4, 2);
      repeat (3) meas_cycle(4, 6);
      check("t5_drain", 64'(exp_q.size()), 64'd0);

      // One-cycle disable keeps the pending result, clears flags
      result_ready = 1'b0;
      restart();
      repeat (3) meas_cycle(4, 6);
      check("t6_overrun_before", 64'(overrun), 64'd1);
      enable = 1'b0;
      wait_n(1);
      enable = 1'b1;
      check("t6_state_idle", 64'(state_dbg), 64'(IDLE));
      check("t6_overrun_cleared", 64'(overrun), 64'd0);
      check("t6_stopped_cleared", 64'(stopped), 64'd0);
      check("t6_valid_kept", 64'(result_valid), 64'd1);
      check("t6_period_kept", 64'(period), 64'd10);
      check("t6_high_time_kept", 64'(high_time), 64'd4);
      wait_n(1);
      check("t6_state_arm", 64'(state_dbg), 64'(ARM));
      push_exp(10, 4, 1);
      result_ready = 1'b1;
      wait_n(1);
      push_exp(10, 4, 2);
      repeat (3) meas_cycle(4, 6);
      check("t6_drain", 64'(exp_q.size()), 64'd0);
      check("t6_overrun_final", 64'(overrun), 64'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
Measures a slow, asynchronous clock such as a divided clock or an external tick. It reports that clock's period and high time, both counted in cycles of the system clock. This is the inverse of clock division: it turns a period back into a count. It feeds status/debug logic and self-checks of divider outputs through a valid/ready result interface.

Parameters:
COUNT_WIDTH, 24, width of the period/high_time counters and outputs.
SYNC_STAGES, 2, number of synchronizer flops on meas_clock (minimum 2).
TIMEOUT, 10000000, cycles without a rising edge before the stopped flag is raised; must be ≤ 2^COUNT_WIDTH-1.

Ports:
clock  input  1  system clock; all logic is on its rising edge
reset  input  1  reset; one clock; reset is asynchronous and active-low
meas_clock  input  1  asynchronous clock under measurement
enable  input  1  measurement enable
result_ready  input  1  consumer accepts the result
result_valid  output  1  period/high_time hold a completed measurement
period  output  COUNT_WIDTH  clock cycles between consecutive meas_clock rising edges
high_time  output  COUNT_WIDTH  clock cycles from a rising edge to the following falling edge
overrun  output  1  sticky: a result was overwritten before it was accepted
stopped  output  1  no rising edge for TIMEOUT cycles

Behaviour:
- Reset (reset=0): all outputs 0, FSM = IDLE, sync/edge flops 0, counter 0. Takes effect asynchronously, including mid-measurement.
- Edge detection:
  - meas_clock passes through SYNC_STAGES flops, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist; each is a one-cycle pulse.
  - Latency is the same for every edge, so it cancels in all measurements.
  - meas_clock high at reset release produces a rise, which only arms the FSM.
- Accuracy: exact for high and low phases of ≥ 2 clocks each; shorter phases may be missed.
- Counter: on rise, counter ← 1; otherwise increments every cycle in MEASURE/STOPPED, saturating at 2^COUNT_WIDTH-1. The counter value on a rise k cycles after the previous rise is k.
- On fall in MEASURE: hi_latch ← counter.
- FSM:
  - IDLE: counter held at 0. enable=1 → ARM.
  - ARM: fall ignored, no result. rise → MEASURE with counter ← 1.
  - MEASURE:
    - rise → result complete: period ← counter, high_time ← hi_latch, result_valid ← 1, counter ← 1.
    - counter == TIMEOUT with no rise → STOPPED; stopped=1 from the next cycle, i.e. TIMEOUT+1 cycles after the last rise pulse.
    - rise in the same cycle as counter == TIMEOUT: rise wins, period = TIMEOUT.
  - STOPPED: no result produced. rise → MEASURE, counter ← 1, stopped ← 0 the next cycle (re-arm; the first result comes on the following rise).
  - Any state with enable=0 → IDLE next cycle. Counter is cleared and stopped and overrun are cleared. A pending result_valid and its data are retained.
- Handshake:
  - Transfer occurs when result_valid & result_ready. result_valid then falls next cycle unless a new result completes in that same cycle, in which case the new data loads and result_valid stays 1 with no overrun.
  - period/high_time are stable while result_valid=1 and result_ready=0.
  - A completion while result_valid=1 & result_ready=0 overwrites the data and sets overrun=1, which stays set until enable=0 or reset.
  - result_ready while result_valid=0 has no effect.

Decomposition:
- Package clock_meter_pkg: FSM state enum (IDLE, ARM, MEASURE, STOPPED) and a COUNT_MAX constant function.
- One sub-module, sync_edge_detect: parameter SYNC_STAGES; ports clock, reset, async_in, rise, fall.

Test Plan:
- enable=1, result_ready=1, meas_clock period 10 clocks (4 high/6 low): first rise arms only → each following rise gives result_valid pulse, period=10, high_time=4, overrun=0.
- meas_clock 3 high/3 low → period=6, high_time=3. Change to 20 high/30 low → the first result spanning the change is 26; subsequent results are period=50, high_time=20.
- result_ready=0 through two completions (period 10) → first completion sets result_valid=1; second sets overrun=1 with period=10. Then result_ready=1 for one cycle → result_valid=0 next cycle, overrun stays 1.
- TIMEOUT=50, meas_clock stopped low after a rise → stopped=1 exactly 51 cycles after that rise pulse, no result. Restart with period 10 → stopped=0 after the next rise; next result period=10.
- reset=0 asserted mid-MEASURE (not aligned to clock) → all outputs 0 immediately. After release, the first rise arms and the second rise produces the first result.
- enable=0 for one cycle mid-measurement with a pending unaccepted result → state IDLE, overrun/stopped cleared, result_valid and period retained. Re-enable → ARM; a new result arrives after two rises.
